// File: rtl/spi_master_engine.sv
// SPI master serial engine: one transfer of 1..MAX_CHAR bits per go_i, with
// programmable sclk divider, selectable tx/rx sclk edges and bit order.
module spi_master_engine #(
    parameter int SS_NB    = 8,
    parameter int MAX_CHAR = 128,
    parameter int DIV_W    = 16
) (
    input  logic                        wb_clk_i,
    input  logic                        wb_rst_i,
    input  logic                        go_i,
    input  logic [$clog2(MAX_CHAR)-1:0] char_len_i,
    input  logic [DIV_W-1:0]            divider_i,
    input  logic                        tx_negedge_i,
    input  logic                        rx_negedge_i,
    input  logic                        lsb_i,
    input  logic [SS_NB-1:0]            ss_sel_i,
    input  logic [MAX_CHAR-1:0]         tx_data_i,
    output logic [MAX_CHAR-1:0]         rx_data_o,
    output logic                        busy_o,
    output logic                        done_o,
    output logic                        sclk_pad_o,
    output logic                        mosi_pad_o,
    input  logic                        miso_pad_i,
    output logic [SS_NB-1:0]            ss_pad_o
);

    localparam int IDX_W = $clog2(MAX_CHAR);

    typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

    state_t              state_reg, state_next;
    logic [DIV_W-1:0]    div_reg, cnt_reg;
    logic [IDX_W-1:0]    len_m1_reg, tx_cnt_reg, rx_cnt_reg;
    logic [IDX_W:0]      edge_cnt_reg;
    logic                tx_neg_reg, rx_neg_reg, lsb_reg;
    logic [MAX_CHAR-1:0] tx_reg, rx_sr_reg, rx_data_reg;
    logic                sclk_reg, mosi_reg, busy_reg, done_reg;
    logic [SS_NB-1:0]    ss_reg;

    logic                tick, last_edge, tx_edge, rx_edge;
    logic [IDX_W-1:0]    tx_idx, rx_idx;

    // tick marks a wb_clk_i cycle on which sclk toggles; the current sclk level
    // tells whether the coming edge is rising (sclk low) or falling (sclk high).
    assign tick      = (state_reg == SHIFT) && (cnt_reg == div_reg);
    assign last_edge = tick && (edge_cnt_reg == {len_m1_reg, 1'b1});
    assign tx_edge   = tick && (sclk_reg == tx_neg_reg);
    assign rx_edge   = tick && (sclk_reg == rx_neg_reg);

    // len_m1 = N-1; a char_len of 0 wraps naturally to MAX_CHAR-1.
    assign tx_idx = lsb_reg ? tx_cnt_reg : (len_m1_reg - tx_cnt_reg);
    assign rx_idx = lsb_reg ? rx_cnt_reg : (len_m1_reg - rx_cnt_reg);

    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE:    if (go_i) state_next = SHIFT;
            SHIFT:   if (last_edge) state_next = DONE;
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            div_reg      <= '0;
            cnt_reg      <= '0;
            len_m1_reg   <= '0;
            tx_cnt_reg   <= '0;
            rx_cnt_reg   <= '0;
            edge_cnt_reg <= '0;
            tx_neg_reg   <= 1'b0;
            rx_neg_reg   <= 1'b0;
            lsb_reg      <= 1'b0;
            tx_reg       <= '0;
            rx_sr_reg    <= '0;
            rx_data_reg  <= '0;
            sclk_reg     <= 1'b0;
            mosi_reg     <= 1'b0;
            busy_reg     <= 1'b0;
            done_reg     <= 1'b0;
            ss_reg       <= '1;
        end else begin
            done_reg <= 1'b0;
            case (state_reg)
                IDLE: begin
                    if (go_i) begin
                        div_reg      <= divider_i;
                        len_m1_reg   <= char_len_i - IDX_W'(1);
                        tx_neg_reg   <= tx_negedge_i;
                        rx_neg_reg   <= rx_negedge_i;
                        lsb_reg      <= lsb_i;
                        tx_reg       <= tx_data_i;
                        ss_reg       <= ~ss_sel_i;
                        busy_reg     <= 1'b1;
                        cnt_reg      <= '0;
                        edge_cnt_reg <= '0;
                        tx_cnt_reg   <= '0;
                        rx_cnt_reg   <= '0;
                        rx_sr_reg    <= '0;
                    end
                end
                SHIFT: begin
                    if (tick) begin
                        cnt_reg      <= '0;
                        sclk_reg     <= ~sclk_reg;
                        edge_cnt_reg <= edge_cnt_reg + 1'b1;
                    end else begin
                        cnt_reg <= cnt_reg + DIV_W'(1);
                    end
                    if (tx_edge) begin
                        mosi_reg   <= tx_reg[tx_idx];
                        tx_cnt_reg <= tx_cnt_reg + IDX_W'(1);
                    end
                    if (rx_edge) begin
                        rx_sr_reg[rx_idx] <= miso_pad_i;
                        rx_cnt_reg        <= rx_cnt_reg + IDX_W'(1);
                    end
                end
                DONE: begin
                    done_reg    <= 1'b1;
                    busy_reg    <= 1'b0;
                    ss_reg      <= '1;
                    rx_data_reg <= rx_sr_reg;
                end
                default: ;
            endcase
        end
    end

    assign rx_data_o  = rx_data_reg;
    assign busy_o     = busy_reg;
    assign done_o     = done_reg;
    assign sclk_pad_o = sclk_reg;
    assign mosi_pad_o = mosi_reg;
    assign ss_pad_o   = ss_reg;

endmodule

// File: tb/tb_spi_master_engine.sv
// Scoreboard bench for spi_master_engine: stimulus pushes expected rx word and
// done cycle; a forked monitor pops and compares on every done_o pulse.
module tb_spi_master_engine;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         go = 1'b0;
    logic [6:0]   char_len = '0;
    logic [15:0]  divider = '0;
    logic         tx_neg = 1'b0;
    logic         rx_neg = 1'b0;
    logic         lsb = 1'b0;
    logic [7:0]   ss_sel = '0;
    logic [127:0] tx_data = '0;
    logic [127:0] rx_data_o;
    logic         busy_o, done_o, sclk_pad_o, mosi_pad_o, miso_pad_i;
    logic [7:0]   ss_pad_o;
    logic         loop_en = 1'b1;
    logic         miso_force = 1'b0;

    assign miso_pad_i = loop_en ? mosi_pad_o : miso_force;

    spi_master_engine #(.SS_NB(8), .MAX_CHAR(128), .DIV_W(16)) dut (
        .wb_clk_i     (clk),
        .wb_rst_i     (rst),
        .go_i         (go),
        .char_len_i   (char_len),
        .divider_i    (divider),
        .tx_negedge_i (tx_neg),
        .rx_negedge_i (rx_neg),
        .lsb_i        (lsb),
        .ss_sel_i     (ss_sel),
        .tx_data_i    (tx_data),
        .rx_data_o    (rx_data_o),
        .busy_o       (busy_o),
        .done_o       (done_o),
        .sclk_pad_o   (sclk_pad_o),
        .mosi_pad_o   (mosi_pad_o),
        .miso_pad_i   (miso_pad_i),
        .ss_pad_o     (ss_pad_o)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [127:0] rx;
        int           cyc;
    } exp_t;

    exp_t exp_q[$];
    logic mosi_log[$];
    int   rises = 0;
    int   checks = 0;
    int   failures = 0;

    task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h required %h", nm, act, exp);
        end else begin
            $display("ok   %s: %h", nm, act);
        end
    endtask

    task automatic monitor();
        logic prev = 1'b0;
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (sclk_pad_o && !prev) begin
                rises++;
                mosi_log.push_back(mosi_pad_o);
            end
            prev = sclk_pad_o;
            if (done_o) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL done_unexpected: got done_o=1 at cycle %0d required no pulse", cyc);
                end else begin
                    e = exp_q.pop_front();
                    chk("sb_rx_data", rx_data_o, e.rx);
                    chk("sb_done_cycle", 128'(cyc), 128'(e.cyc));
                end
            end
        end
    endtask

    task automatic start(input logic [6:0] len, input logic [15:0] div, input logic txn,
                         input logic rxn, input logic lsbf, input logic [7:0] sel,
                         input logic [127:0] tx, input logic push, input logic [127:0] exp_rx,
                         output int go_cyc);
        int   n;
        exp_t e;
        @(negedge clk);
        char_len = len;
        divider  = div;
        tx_neg   = txn;
        rx_neg   = rxn;
        lsb      = lsbf;
        ss_sel   = sel;
        tx_data  = tx;
        go       = 1'b1;
        go_cyc   = cyc + 1;
        n = (len == 7'd0) ? 128 : int'(len);
        if (push) begin
            e.rx  = exp_rx;
            e.cyc = go_cyc + 2 * n * (int'(div) + 1) + 1;
            exp_q.push_back(e);
        end
        @(negedge clk);
        go = 1'b0;
    endtask

    task automatic wait_done(input int limit, input string nm);
        logic seen = 1'b0;
        for (int i = 0; i < limit && !seen; i++) begin
            @(posedge clk);
            #1;
            if (done_o) seen = 1'b1;
        end
        chk(nm, 128'(seen), 128'd1);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: got no end of run required finish");
        $fatal(1);
    end

    initial begin
        int           g, r0, l0, dn;
        logic [7:0]   bits;
        logic [127:0] word;
        exp_t         e;

        fork
            monitor();
        join_none

        // reset values
        repeat (3) @(negedge clk);
        chk("rst_sclk", 128'(sclk_pad_o), 128'd0);
        chk("rst_mosi", 128'(mosi_pad_o), 128'd0);
        chk("rst_ss", 128'(ss_pad_o), 128'hFF);
        chk("rst_busy", 128'(busy_o), 128'd0);
        chk("rst_done", 128'(done_o), 128'd0);
        chk("rst_rx", rx_data_o, 128'd0);
        rst = 1'b0;
        repeat (2) @(negedge clk);

        // loopback, N=8, 0xA5, div=1, MSB first; ss_sel changed mid-transfer
        r0 = rises;
        l0 = mosi_log.size();
        start(7'd8, 16'd1, 1'b0, 1'b1, 1'b0, 8'h04, 128'hA5, 1'b1, 128'hA5, g);
        chk("t1_busy", 128'(busy_o), 128'd1);
        chk("t1_ss_active", 128'(ss_pad_o), 128'hFB);
        ss_sel = 8'hFF;
        repeat (5) @(negedge clk);
        chk("t1_ss_latched", 128'(ss_pad_o), 128'hFB);
        wait_done(60, "t1_done_seen");
        chk("t1_ss_release", 128'(ss_pad_o), 128'hFF);
        chk("t1_busy_clear", 128'(busy_o), 128'd0);
        @(negedge clk);
        chk("t1_sclk_pulses", 128'(rises - r0), 128'd8);
        bits = '0;
        for (int i = 0; i < 8; i++) bits = {bits[6:0], mosi_log[l0 + i]};
        chk("t1_mosi_seq", 128'(bits), 128'hA5);

        // LSB first, N=4, tx=1, miso tied high
        loop_en    = 1'b0;
        miso_force = 1'b1;
        r0 = rises;
        l0 = mosi_log.size();
        start(7'd4, 16'd1, 1'b0, 1'b1, 1'b1, 8'h01, 128'h1, 1'b1, 128'hF, g);
        wait_done(40, "t2_done_seen");
        @(negedge clk);
        chk("t2_sclk_pulses", 128'(rises - r0), 128'd4);
        bits = '0;
        for (int i = 0; i < 4; i++) bits = {bits[6:0], mosi_log[l0 + i]};
        chk("t2_mosi_seq", 128'(bits), 128'h8);
        repeat (3) @(negedge clk);
        chk("t2_rx_hold", rx_data_o, 128'hF);

        // char_len=0 (128 bits), div=0, loopback random word
        loop_en = 1'b1;
        word = {$urandom, $urandom, $urandom, $urandom};
        r0 = rises;
        start(7'd0, 16'd0, 1'b0, 1'b1, 1'b0, 8'h02, word, 1'b1, word, g);
        wait_done(400, "t3_done_seen");
        @(negedge clk);
        chk("t3_sclk_pulses", 128'(rises - r0), 128'd128);

        // go held high: ignored while busy and in done cycle, accepted right after
        @(negedge clk);
        char_len = 7'd8;
        divider  = 16'd0;
        tx_neg   = 1'b0;
        rx_neg   = 1'b1;
        lsb      = 1'b0;
        ss_sel   = 8'h04;
        tx_data  = 128'h3C;
        go       = 1'b1;
        g        = cyc + 1;
        e.rx = 128'h3C; e.cyc = g + 17;      exp_q.push_back(e);
        e.rx = 128'hC3; e.cyc = g + 18 + 17; exp_q.push_back(e);
        @(negedge clk);
        tx_data = 128'hC3;
        chk("t4_busy", 128'(busy_o), 128'd1);
        wait_done(40, "t4_first_done");
        chk("t4_ss_gap", 128'(ss_pad_o), 128'hFF);
        @(posedge clk);
        #1;
        chk("t4_restart_busy", 128'(busy_o), 128'd1);
        chk("t4_restart_ss", 128'(ss_pad_o), 128'hFB);
        go = 1'b0;
        wait_done(40, "t4_second_done");
        @(negedge clk);

        // reset pulsed at edge 5 of a 16-bit transfer (div=1 -> cycle g+10)
        start(7'd16, 16'd1, 1'b0, 1'b1, 1'b0, 8'h04, 128'hBEEF, 1'b0, 128'd0, g);
        for (int i = 0; i < 100 && cyc != g + 9; i++) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("t5_sclk", 128'(sclk_pad_o), 128'd0);
        chk("t5_ss", 128'(ss_pad_o), 128'hFF);
        chk("t5_busy", 128'(busy_o), 128'd0);
        chk("t5_rx_cleared", rx_data_o, 128'd0);
        dn = 0;
        repeat (60) begin
            @(posedge clk);
            #1;
            if (done_o) dn++;
        end
        chk("t5_no_done", 128'(dn), 128'd0);

        @(negedge clk);
        chk("sb_empty", 128'(exp_q.size()), 128'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
